ibex_rf_write_arbiter: RTL and testbench
========================================

# ibex_rf_write_arbiter

Controller for the single write port of the integer register file. It shares that port between the execute-stage writeback (EX) and the load/store-unit writeback (LSU) using round-robin arbitration with a valid/grant handshake. It also sequences a hardware clear that walks x1..x(NUM_WORDS-1) and writes zero to each. It sits between the ID/EX writeback muxing and the register file's `waddr_a_i`/`wdata_a_i`/`we_a_i` inputs.

## Interface
- `RV32E`, default 0: 1 selects 16 registers, 0 selects 32 registers. NUM_WORDS = 16 or 32.
- `DataWidth`, default 32: width of write data.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `ex_req_i`  in  1  EX write request; held until granted.
- `ex_addr_i`  in  5  EX destination register.
- `ex_wdata_i`  in  DataWidth  EX write data.
- `ex_gnt_o`  out  1  EX write accepted this cycle.
- `lsu_req_i`  in  1  LSU write request; held until granted.
- `lsu_addr_i`  in  5  LSU destination register.
- `lsu_wdata_i`  in  DataWidth  LSU write data.
- `lsu_gnt_o`  out  1  LSU write accepted this cycle.
- `clr_req_i`  in  1  request a full register clear (level, sampled in IDLE).
- `clr_busy_o`  out  1  clear sequence in progress.
- `clr_done_o`  out  1  one-cycle pulse after the last clear write.
- `rf_waddr_o`  out  5  register file write address.
- `rf_wdata_o`  out  DataWidth  register file write data.
- `rf_we_o`  out  1  register file write enable.

## Operation
- FSM has two states: IDLE and CLEAR. Reset state is IDLE.
- **IDLE arbitration** (combinational grant, same-cycle write):
  - Only one requester active: that requester is granted. rf_* outputs carry its addr and data, and `rf_we_o`=1.
  - Both active: grant goes to the requester that did not win the last contended cycle. The `last_winner` flop updates only on contended cycles.
  - Neither active: `rf_we_o`=0, and `rf_waddr_o`/`rf_wdata_o`=0.
  - At most one grant per cycle. A gnt is always accompanied by `rf_we_o`=1.
  - Address 0 is forwarded unchanged; the register file discards it. It is still granted.
- **IDLE→CLEAR**: taken when `clr_req_i`=1 in IDLE. Arbitration still proceeds normally in that cycle. A 5-bit counter loads 1.
- **CLEAR**:
  - `rf_we_o`=1, `rf_waddr_o`=counter, `rf_wdata_o`=0.
  - Both grants are forced to 0, so requesters stall.
  - Counter increments each cycle.
  - When counter = NUM_WORDS-1, next state is IDLE and the `clr_done_o` flop sets.
- `clr_req_i` is ignored while in CLEAR. If it is still high on return to IDLE, a new clear starts.
- `clr_busy_o` = (state == CLEAR).
- `clr_done_o` is registered. It is high for exactly the first IDLE cycle after CLEAR; arbitration resumes in that same cycle.
- `last_winner` is unchanged by a clear.

## Timing
- Reset values: state=IDLE, counter=0, `last_winner`=LSU (so EX wins the first contention), `clr_done_o`=0, `clr_busy_o`=0.
- Outputs during reset: all grants and `rf_we_o`=0; `rf_waddr_o`/`rf_wdata_o`=0.
- Grant latency is 0 cycles: gnt and the rf write happen in the request cycle. Data is written to the register file at the next clock edge.
- Requesters must hold req/addr/data stable until gnt. A withdrawn request is a protocol error and is not checked.
- Clear duration is NUM_WORDS-1 cycles with `clr_busy_o` high: 31 for RV32I, 15 for RV32E. `clr_done_o` follows in the next cycle.
- Maximum stall of one requester under continuous contention is 1 cycle, excluding clear.
- Reset asserted mid-CLEAR aborts the sequence immediately (asynchronous). No done pulse is produced; the FSM returns to IDLE.

## Test plan
- **Single requester**: EX req, addr=5, data=0xDEADBEEF, LSU idle → `ex_gnt_o`=1, `rf_we_o`=1, `rf_waddr_o`=5, `rf_wdata_o`=0xDEADBEEF the same cycle; `lsu_gnt_o`=0.
- **Contention round-robin**: EX and LSU both request for 4 cycles after reset, each re-requesting after gnt → grants EX, LSU, EX, LSU; never both in one cycle.
- **Clear sequence (RV32E=0)**: pulse `clr_req_i` in IDLE → `clr_busy_o` high for 31 cycles; `rf_waddr_o` walks 1..31 with `rf_wdata_o`=0; `clr_done_o` is high for 1 cycle after; a readback of all registers returns 0.
- **Stall during clear**: LSU requests addr=7 while CLEAR is at counter 10 → `lsu_gnt_o`=0 until the `clr_done_o` cycle. LSU is granted in that cycle and x7 holds the LSU data afterwards.
- **RV32E clear with held request**: RV32E=1, `clr_req_i` held high → first clear runs 15 cycles. `clr_done_o` pulses, and a second clear starts on the following edge.
- **Reset mid-clear**: `rst_ni` driven low at counter 12 → `clr_busy_o`=0 and `rf_we_o`=0 immediately. After release: state IDLE, no `clr_done_o` pulse, and EX wins the first contention.

Source files
------------

// File: rtl/ibex_rf_write_arbiter.sv
// Register file write-port arbiter: round-robin EX/LSU sharing
// plus a hardware clear sequence that zeroes x1..x(N-1).
module ibex_rf_write_arbiter #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_req_i,
  input  logic [4:0]           ex_addr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_gnt_o,
  input  logic                 lsu_req_i,
  input  logic [4:0]           lsu_addr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 lsu_gnt_o,
  input  logic                 clr_req_i,
  output logic                 clr_busy_o,
  output logic                 clr_done_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o
);

  localparam logic [4:0] LastIdx = RV32E ? 5'd15 : 5'd31;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       last_lsu_q, last_lsu_d;
  logic       done_q, done_d;

  logic both;
  logic pick_ex;
  logic pick_lsu;

  // On contention the side that did not win last time is preferred
  assign both     = ex_req_i & lsu_req_i;
  assign pick_ex  = ex_req_i & (~lsu_req_i | last_lsu_q);
  assign pick_lsu = lsu_req_i & ~pick_ex;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      last_lsu_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_lsu_q <= last_lsu_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 5'd1;
    last_lsu_d = last_lsu_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (both) begin
          last_lsu_d = pick_lsu;
        end
        if (clr_req_i) begin
          state_d = CLEAR;
          cnt_d   = 5'd1;
        end
      end
      CLEAR: begin
        if (cnt_q == LastIdx) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are held quiet while reset is asserted
  always_comb begin
    ex_gnt_o   = 1'b0;
    lsu_gnt_o  = 1'b0;
    rf_we_o    = 1'b0;
    rf_waddr_o = 5'd0;
    rf_wdata_o = '0;
    if (rst_ni) begin
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            pick_ex: begin
              ex_gnt_o   = 1'b1;
              rf_we_o    = 1'b1;
              rf_waddr_o = ex_addr_i;
              rf_wdata_o = ex_wdata_i;
            end
            pick_lsu: begin
              lsu_gnt_o  = 1'b1;
              rf_we_o    = 1'b1;
              rf_waddr_o = lsu_addr_i;
              rf_wdata_o = lsu_wdata_i;
            end
            default: ;
          endcase
        end
        CLEAR: begin
          rf_we_o    = 1'b1;
          rf_waddr_o = cnt_q;
        end
        default: ;
      endcase
    end
  end

  assign clr_busy_o = (state_q == CLEAR);
  assign clr_done_o = done_q;

endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// Directed bench for ibex_rf_write_arbiter (RV32I and RV32E),
// with a small register file model fed by the write port.
module tb_ibex_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_req, lsu_req, clr_req, clr_req_e;
  logic [4:0]  ex_addr, lsu_addr;
  logic [31:0] ex_wdata, lsu_wdata;

  logic        ex_gnt, lsu_gnt, busy, done, we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        ex_gnt_e, lsu_gnt_e, busy_e, done_e, we_e;
  logic [4:0]  waddr_e;
  logic [31:0] wdata_e;

  logic [31:0] rf [32];
  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ibex_rf_write_arbiter #(.RV32E(1'b0), .DataWidth(32)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ex_req_i(ex_req), .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata),
    .ex_gnt_o(ex_gnt),
    .lsu_req_i(lsu_req), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
    .lsu_gnt_o(lsu_gnt),
    .clr_req_i(clr_req), .clr_busy_o(busy), .clr_done_o(done),
    .rf_waddr_o(waddr), .rf_wdata_o(wdata), .rf_we_o(we)
  );

  ibex_rf_write_arbiter #(.RV32E(1'b1), .DataWidth(32)) u_dut_e (
    .clk_i(clk), .rst_ni(rst_n),
    .ex_req_i(ex_req), .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata),
    .ex_gnt_o(ex_gnt_e),
    .lsu_req_i(lsu_req), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
    .lsu_gnt_o(lsu_gnt_e),
    .clr_req_i(clr_req_e), .clr_busy_o(busy_e), .clr_done_o(done_e),
    .rf_waddr_o(waddr_e), .rf_wdata_o(wdata_e), .rf_we_o(we_e)
  );

  always @(posedge clk) begin
    if (we && waddr != 5'd0) rf[waddr] <= wdata;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic st();
    #2;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hA5A5_0000 + i;
    rst_n = 1'b0;
    clr_req = 1'b0; clr_req_e = 1'b0;
    ex_req = 1'b1; ex_addr = 5'd3; ex_wdata = 32'h1111_0003;
    lsu_req = 1'b1; lsu_addr = 5'd4; lsu_wdata = 32'h2222_0004;
    st();
    chk("rst_ex_gnt", {31'd0, ex_gnt}, 32'd0);
    chk("rst_lsu_gnt", {31'd0, lsu_gnt}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_waddr", {27'd0, waddr}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;

    // contention: EX, LSU, EX, LSU
    for (int i = 0; i < 4; i++) begin
      st();
      chk("rr_ex_gnt", {31'd0, ex_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_lsu_gnt", {31'd0, lsu_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_waddr", {27'd0, waddr}, (i % 2 == 0) ? 32'd3 : 32'd4);
      chk("rr_wdata", wdata,
          (i % 2 == 0) ? 32'h1111_0003 : 32'h2222_0004);
      cyc();
    end

    lsu_req = 1'b0;
    ex_addr = 5'd5; ex_wdata = 32'hDEAD_BEEF;
    st();
    chk("single_ex_gnt", {31'd0, ex_gnt}, 32'd1);
    chk("single_lsu_gnt", {31'd0, lsu_gnt}, 32'd0);
    chk("single_we", {31'd0, we}, 32'd1);
    chk("single_waddr", {27'd0, waddr}, 32'd5);
    chk("single_wdata", wdata, 32'hDEAD_BEEF);

    cyc();
    ex_req = 1'b0;
    lsu_req = 1'b1; lsu_addr = 5'd0; lsu_wdata = 32'h0000_1234;
    st();
    chk("x0_lsu_gnt", {31'd0, lsu_gnt}, 32'd1);
    chk("x0_we", {31'd0, we}, 32'd1);
    chk("x0_waddr", {27'd0, waddr}, 32'd0);
    chk("x0_wdata", wdata, 32'h0000_1234);

    cyc();
    lsu_req = 1'b0;
    st();
    chk("idle_we", {31'd0, we}, 32'd0);
    chk("idle_waddr", {27'd0, waddr}, 32'd0);
    chk("idle_wdata", wdata, 32'd0);

    // clear entry cycle still arbitrates
    cyc();
    clr_req = 1'b1;
    ex_req = 1'b1; ex_addr = 5'd9; ex_wdata = 32'h0000_0099;
    st();
    chk("clr_entry_ex_gnt", {31'd0, ex_gnt}, 32'd1);
    chk("clr_entry_busy", {31'd0, busy}, 32'd0);
    for (int i = 1; i <= 31; i++) begin
      cyc();
      if (i == 1) begin
        clr_req = 1'b0;
        ex_req = 1'b0;
      end
      if (i == 10) begin
        lsu_req = 1'b1; lsu_addr = 5'd7; lsu_wdata = 32'h7777_0007;
      end
      st();
      chk("clr_busy", {31'd0, busy}, 32'd1);
      chk("clr_we", {31'd0, we}, 32'd1);
      chk("clr_waddr", {27'd0, waddr}, i);
      chk("clr_wdata", wdata, 32'd0);
      chk("clr_lsu_stall", {31'd0, lsu_gnt}, 32'd0);
    end
    cyc();
    st();
    chk("clr_done", {31'd0, done}, 32'd1);
    chk("clr_done_busy", {31'd0, busy}, 32'd0);
    chk("clr_done_lsu_gnt", {31'd0, lsu_gnt}, 32'd1);
    chk("clr_done_waddr", {27'd0, waddr}, 32'd7);
    chk("clr_done_wdata", wdata, 32'h7777_0007);
    cyc();
    lsu_req = 1'b0;
    st();
    chk("clr_done_pulse", {31'd0, done}, 32'd0);
    for (int i = 1; i < 32; i++) begin
      chk("readback", rf[i], (i == 7) ? 32'h7777_0007 : 32'd0);
    end

    // last winner survives the clear: EX, LSU, then EX again
    cyc();
    ex_req = 1'b1; ex_addr = 5'd3; ex_wdata = 32'h1111_0003;
    lsu_req = 1'b1; lsu_addr = 5'd4; lsu_wdata = 32'h2222_0004;
    for (int i = 0; i < 3; i++) begin
      st();
      chk("post_clr_ex_gnt", {31'd0, ex_gnt},
          (i != 1) ? 32'd1 : 32'd0);
      chk("post_clr_lsu_gnt", {31'd0, lsu_gnt},
          (i == 1) ? 32'd1 : 32'd0);
      cyc();
    end

    // reset in the middle of a clear
    ex_req = 1'b0; lsu_req = 1'b0;
    clr_req = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (i == 1) clr_req = 1'b0;
    end
    st();
    chk("mid_waddr", {27'd0, waddr}, 32'd12);
    ex_req = 1'b1; lsu_req = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_we", {31'd0, we}, 32'd0);
    chk("mid_rst_ex_gnt", {31'd0, ex_gnt}, 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    st();
    chk("post_rst_ex_gnt", {31'd0, ex_gnt}, 32'd1);
    chk("post_rst_lsu_gnt", {31'd0, lsu_gnt}, 32'd0);
    chk("post_rst_done", {31'd0, done}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    cyc();
    st();
    chk("post_rst2_lsu_gnt", {31'd0, lsu_gnt}, 32'd1);
    chk("post_rst2_done", {31'd0, done}, 32'd0);

    // RV32E clear with clr_req held high
    cyc();
    ex_req = 1'b0; lsu_req = 1'b0;
    clr_req_e = 1'b1;
    st();
    chk("e_entry_busy", {31'd0, busy_e}, 32'd0);
    for (int i = 1; i <= 15; i++) begin
      cyc();
      st();
      chk("e_busy", {31'd0, busy_e}, 32'd1);
      chk("e_waddr", {27'd0, waddr_e}, i);
      chk("e_wdata", wdata_e, 32'd0);
    end
    cyc();
    st();
    chk("e_done", {31'd0, done_e}, 32'd1);
    chk("e_done_busy", {31'd0, busy_e}, 32'd0);
    cyc();
    st();
    chk("e_restart_busy", {31'd0, busy_e}, 32'd1);
    chk("e_restart_waddr", {27'd0, waddr_e}, 32'd1);
    chk("e_restart_done", {31'd0, done_e}, 32'd0);
    clr_req_e = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
